beu_clmul: RTL and testbench



---
 rtl/beu_clmul.sv | 119 +++++++++++
 tb/tb_beu_clmul.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/beu_clmul.sv
// Iterative carry-less multiplier (Zbc clmul/clmulh/clmulr) for the BEU_CLMUL path.
// Consumes STEP multiplier bits per cycle; optional early exit once the multiplier runs out of ones.
module beu_clmul #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STEP       = 4,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic            s_clk_i,
  input  logic            s_resetn_i,
  input  logic            s_start_i,
  input  logic            s_kill_i,
  input  logic [1:0]      s_mode_i,
  input  logic [XLEN-1:0] s_op1_i,
  input  logic [XLEN-1:0] s_op2_i,
  output logic            s_busy_o,
  output logic            s_valid_o,
  output logic [XLEN-1:0] s_result_o
);

  localparam int unsigned N     = XLEN / STEP;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_mcand;
  logic [PW-1:0]     r_acc;
  logic [XLEN-1:0]   r_mplier;
  logic [1:0]        r_mode;
  logic [CNT_W-1:0]  r_cnt;

  logic [PW-1:0]     w_acc_nxt;
  logic [PW-1:0]     w_mcand_nxt;
  logic [XLEN-1:0]   w_mplier_nxt;
  logic              w_last;
  logic [XLEN-1:0]   w_result;

  // One iteration: fold STEP partial products into the accumulator, then advance.
  always_comb begin
    w_acc_nxt = r_acc;
    for (int unsigned j = 0; j < STEP; j++) begin
      if (r_mplier[j]) begin
        w_acc_nxt = w_acc_nxt ^ (r_mcand << j);
      end
    end
    w_mcand_nxt  = r_mcand << STEP;
    w_mplier_nxt = r_mplier >> STEP;
    w_last       = (r_cnt == CNT_W'(N - 1)) ||
                   ((EARLY_EXIT != 0) && (w_mplier_nxt == '0));
  end

  // Result slice of the final product; reserved mode yields zero.
  always_comb begin
    w_result = '0;
    case (r_mode)
      2'b00:   w_result = w_acc_nxt[XLEN-1:0];
      2'b01:   w_result = w_acc_nxt[PW-1:XLEN];
      2'b10:   w_result = w_acc_nxt[PW-2:XLEN-1];
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_state    <= ST_IDLE;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_mplier   <= '0;
      r_mode     <= '0;
      r_cnt      <= '0;
      s_busy_o   <= 1'b0;
      s_valid_o  <= 1'b0;
      s_result_o <= '0;
    end else if (s_kill_i) begin
      // Flush beats any concurrent start; result register is left stale.
      r_state   <= ST_IDLE;
      s_busy_o  <= 1'b0;
      s_valid_o <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (s_start_i) begin
            r_mcand   <= {{XLEN{1'b0}}, s_op1_i};
            r_mplier  <= s_op2_i;
            r_mode    <= s_mode_i;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_state   <= ST_BUSY;
            s_busy_o  <= 1'b1;
            s_valid_o <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= w_mcand_nxt;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            s_result_o <= w_result;
            s_busy_o   <= 1'b0;
            s_valid_o  <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          s_busy_o  <= 1'b0;
          s_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beu_clmul.sv
// Directed and random checks of beu_clmul across several STEP / EARLY_EXIT configurations.
module tb_beu_clmul;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [1:0]  mode;
  logic [31:0] op1;
  logic [31:0] op2;

  logic        busy_a, busy_b, busy_c, busy_d, busy_e;
  logic        valid_a, valid_b, valid_c, valid_d, valid_e;
  logic [31:0] res_a, res_b, res_c, res_d, res_e;
  logic [4:0]  w_busy;
  logic [4:0]  w_valid;

  int n_tests = 0;
  int n_fail  = 0;

  assign w_busy  = {busy_e, busy_d, busy_c, busy_b, busy_a};
  assign w_valid = {valid_e, valid_d, valid_c, valid_b, valid_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: STEP4 no early exit, b: STEP4 early exit, c: STEP1, d: STEP2 early exit, e: STEP8
  beu_clmul #(.XLEN(32), .STEP(4), .EARLY_EXIT(0)) u_a (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_start_i(start), .s_kill_i(kill),
    .s_mode_i(mode), .s_op1_i(op1), .s_op2_i(op2),
    .s_busy_o(busy_a), .s_valid_o(valid_a), .s_result_o(res_a));
  beu_clmul #(.XLEN(32), .STEP(4), .EARLY_EXIT(1)) u_b (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_start_i(start), .s_kill_i(kill),
    .s_mode_i(mode), .s_op1_i(op1), .s_op2_i(op2),
    .s_busy_o(busy_b), .s_valid_o(valid_b), .s_result_o(res_b));
  beu_clmul #(.XLEN(32), .STEP(1), .EARLY_EXIT(0)) u_c (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_start_i(start), .s_kill_i(kill),
    .s_mode_i(mode), .s_op1_i(op1), .s_op2_i(op2),
    .s_busy_o(busy_c), .s_valid_o(valid_c), .s_result_o(res_c));
  beu_clmul #(.XLEN(32), .STEP(2), .EARLY_EXIT(1)) u_d (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_start_i(start), .s_kill_i(kill),
    .s_mode_i(mode), .s_op1_i(op1), .s_op2_i(op2),
    .s_busy_o(busy_d), .s_valid_o(valid_d), .s_result_o(res_d));
  beu_clmul #(.XLEN(32), .STEP(8), .EARLY_EXIT(0)) u_e (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_start_i(start), .s_kill_i(kill),
    .s_mode_i(mode), .s_op1_i(op1), .s_op2_i(op2),
    .s_busy_o(busy_e), .s_valid_o(valid_e), .s_result_o(res_e));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full 64-bit carry-less product, then slice by mode.
  function automatic logic [31:0] ref_clmul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] m);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ ({32'b0, a} << i);
    end
    case (m)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return p[62:31];
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ee_lat(input logic [31:0] b, input int step);
    int msb;
    msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + step) / step;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    @(negedge clk);
    op1 = a; op2 = b; mode = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int idx, output int lat);
    lat = 0;
    while (!w_valid[idx] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_all_idle();
    int t;
    t = 0;
    while (w_busy != 5'b0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) check_eq("idle_timeout", 64'(w_busy), 64'h0);
  endtask

  task automatic check_all(input string tag, input logic [31:0] exp);
    check_eq({tag, "_a"}, 64'(res_a), 64'(exp));
    check_eq({tag, "_b"}, 64'(res_b), 64'(exp));
    check_eq({tag, "_c"}, 64'(res_c), 64'(exp));
    check_eq({tag, "_d"}, 64'(res_d), 64'(exp));
    check_eq({tag, "_e"}, 64'(res_e), 64'(exp));
    check_eq({tag, "_valid"}, 64'(w_valid), 64'h1F);
  endtask

  initial begin
    int lat;
    logic [31:0] a, b, ref_r;
    logic [1:0] m;

    rst_n = 1'b0; start = 1'b0; kill = 1'b0; mode = 2'b00; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(w_busy), 64'h0);
    check_eq("rst_valid", 64'(w_valid), 64'h0);
    check_eq("rst_result", 64'(res_a), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic clmul and fixed latency
    start_op(32'h3, 32'h3, 2'b00);
    check_eq("t1_busy", 64'(busy_a), 64'h1);
    wait_valid(0, lat);
    check_eq("t1_lat_a", 64'(lat), 64'd8);
    wait_all_idle();
    check_all("t1_res", 32'h5);

    // All ones, three modes
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    wait_valid(0, lat);
    check_eq("t2_lat_a", 64'(lat), 64'd8);
    wait_all_idle();
    check_all("t2_clmul", 32'h5555_5555);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
    wait_valid(1, lat);
    check_eq("t2_lat_b", 64'(lat), 64'd8);
    wait_all_idle();
    check_all("t2_clmulh", 32'h5555_5555);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10);
    wait_all_idle();
    check_all("t2_clmulr", 32'hAAAA_AAAA);

    // MSB x MSB
    start_op(32'h8000_0000, 32'h8000_0000, 2'b00);
    wait_all_idle();
    check_all("t3_clmul", 32'h0);
    start_op(32'h8000_0000, 32'h8000_0000, 2'b01);
    wait_all_idle();
    check_all("t3_clmulh", 32'h4000_0000);
    start_op(32'h8000_0000, 32'h8000_0000, 2'b10);
    wait_all_idle();
    check_all("t3_clmulr", 32'h8000_0000);

    // Early exit latencies
    start_op(32'h1234_5678, 32'h3, 2'b00);
    wait_valid(1, lat);
    check_eq("t4_lat_op2_3", 64'(lat), 64'd1);
    wait_all_idle();
    check_all("t4_res_3", ref_clmul(32'h1234_5678, 32'h3, 2'b00));
    start_op(32'h1234_5678, 32'h0001_0000, 2'b01);
    wait_valid(1, lat);
    check_eq("t4_lat_bit16", 64'(lat), 64'd5);
    wait_all_idle();
    check_all("t4_res_bit16", 32'h0000_1234);
    start_op(32'hDEAD_BEEF, 32'h0, 2'b00);
    wait_valid(1, lat);
    check_eq("t4_lat_zero", 64'(lat), 64'd1);
    check_eq("t4_res_zero", 64'(res_b), 64'h0);
    wait_all_idle();
    start_op(32'hDEAD_BEEF, 32'hFFFF_FFFF, 2'b11);
    wait_all_idle();
    check_all("t4_reserved", 32'h0);

    // Kill with simultaneous start
    start_op(32'hDEAD_BEEF, 32'hFFFF_FFFF, 2'b00);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    kill = 1'b1; start = 1'b1; op1 = 32'h5; op2 = 32'h7;
    @(posedge clk);
    #1;
    kill = 1'b0; start = 1'b0;
    check_eq("t5_kill_busy", 64'(w_busy), 64'h0);
    check_eq("t5_kill_valid", 64'(w_valid), 64'h0);
    start_op(32'h5, 32'h7, 2'b00);
    check_eq("t5_restart_busy", 64'(busy_a), 64'h1);
    wait_all_idle();
    check_all("t5_res", 32'h1B);

    // Start from DONE: valid drops as busy rises
    start_op(32'hF0, 32'h11, 2'b00);
    check_eq("t6_done_valid", 64'(valid_a), 64'h0);
    check_eq("t6_done_busy", 64'(busy_a), 64'h1);
    wait_valid(0, lat);
    check_eq("t6_lat", 64'(lat), 64'd8);
    wait_all_idle();
    check_all("t6_res", 32'hFF0);

    // Start pulse while busy is ignored; operand changes have no effect
    start_op(32'h1357_9BDF, 32'hF00F_0FF0, 2'b01);
    @(negedge clk);
    op1 = 32'hFFFF_FFFF; op2 = 32'h1; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_all_idle();
    check_all("t6_ignore", ref_clmul(32'h1357_9BDF, 32'hF00F_0FF0, 2'b01));

    // Async reset mid-operation
    start_op(32'hCAFE_F00D, 32'hFFFF_FFFF, 2'b00);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", 64'(w_busy), 64'h0);
    check_eq("t6_rst_valid", 64'(w_valid), 64'h0);
    check_eq("t6_rst_res", 64'(res_a), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random sweep across all configurations
    for (int k = 0; k < 1000; k++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      m = 2'($urandom_range(0, 3));
      ref_r = ref_clmul(a, b, m);
      start_op(a, b, m);
      wait_valid(1, lat);
      check_eq("rnd_lat_b", 64'(lat), 64'(ee_lat(b, 4)));
      wait_all_idle();
      check_all("rnd", ref_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
